// File: rtl/trdb_sample_fifo_pkg.sv
// Shared types for the trace sample path: sample word layout and field widths.
package trdb_pkg;

  localparam int XLEN      = 32;
  localparam int CAUSE_LEN = 5;
  localparam int PRIV_LEN  = 3;

  // 108-bit sample word; resync sits in the LSB
  typedef struct packed {
    logic                 exception;
    logic                 interrupt;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
    logic [XLEN-1:0]      iaddr;
    logic [XLEN-1:0]      instr;
    logic                 compressed;
    logic                 resync;
  } trdb_sample_t;

endpackage

// File: rtl/trdb_sample_fifo_if.sv
// Retire-side capture inputs and encoder-side sample handshake of the trace sample FIFO.
interface trdb_sample_fifo_if #(parameter int CNT_W = 16);
  import trdb_pkg::*;

  logic                 trace_enable_i;
  logic                 flush_i;
  logic                 ivalid_i;
  logic                 iexception_i;
  logic                 interrupt_i;
  logic [CAUSE_LEN-1:0] cause_i;
  logic [XLEN-1:0]      tval_i;
  logic [PRIV_LEN-1:0]  priv_i;
  logic [XLEN-1:0]      iaddr_i;
  logic [XLEN-1:0]      instr_i;
  logic                 compressed_i;
  logic                 sample_valid_o;
  logic                 sample_ready_i;
  trdb_sample_t         sample_o;
  logic                 overflow_o;
  logic [CNT_W-1:0]     lost_cnt_o;

  modport master (
    output trace_enable_i, flush_i, ivalid_i, iexception_i, interrupt_i, cause_i,
           tval_i, priv_i, iaddr_i, instr_i, compressed_i, sample_ready_i,
    input  sample_valid_o, sample_o, overflow_o, lost_cnt_o
  );

  modport slave (
    input  trace_enable_i, flush_i, ivalid_i, iexception_i, interrupt_i, cause_i,
           tval_i, priv_i, iaddr_i, instr_i, compressed_i, sample_ready_i,
    output sample_valid_o, sample_o, overflow_o, lost_cnt_o
  );

endinterface

// File: rtl/trdb_sync_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush; storage is not reset.
module trdb_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          pop_ok, push_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop && !empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/trdb_sample_fifo.sv
// Retire-sample capture, resync marking and loss accounting in front of a sample FIFO.
// Optional lost-sample counter: define TRDB_LOST_CNT_EN.
module trdb_sample_fifo
  import trdb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  trdb_sample_fifo_if.slave   bus
);
  logic         capture, pop, push, drop, full, empty;
  logic         resync_pending, overflow;
  trdb_sample_t din;

  assign capture = bus.trace_enable_i && (bus.ivalid_i || bus.iexception_i);
  assign pop     = !empty && bus.sample_ready_i;
  assign push    = capture && !bus.flush_i && (!full || pop);
  assign drop    = capture && !bus.flush_i && full && !pop;

  always_comb begin
    din            = '0;
    din.exception  = bus.iexception_i;
    din.interrupt  = bus.interrupt_i;
    din.cause      = bus.cause_i;
    din.tval       = bus.tval_i;
    din.priv       = bus.priv_i;
    din.iaddr      = bus.iaddr_i;
    din.instr      = bus.instr_i;
    din.compressed = bus.compressed_i;
    din.resync     = resync_pending;
  end

  trdb_sync_fifo #(.DEPTH(DEPTH), .W($bits(trdb_sample_t))) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (bus.flush_i),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (bus.sample_o),
    .full  (full),
    .empty (empty)
  );

  // holding pending high while disabled marks the first sample after enable rises
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.flush_i) begin
      resync_pending <= 1'b1;
      overflow       <= 1'b0;
    end else if (drop) begin
      resync_pending <= 1'b1;
      overflow       <= 1'b1;
    end else if (push) begin
      resync_pending <= 1'b0;
    end else if (!bus.trace_enable_i) begin
      resync_pending <= 1'b1;
    end
  end

  assign bus.sample_valid_o = !empty;
  assign bus.overflow_o     = overflow;

`ifdef TRDB_LOST_CNT_EN
  logic [CNT_W-1:0] lost_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.flush_i)   lost_cnt <= '0;
    else if (drop && lost_cnt != '1) lost_cnt <= lost_cnt + CNT_W'(1);
  end

  assign bus.lost_cnt_o = lost_cnt;
`else
  assign bus.lost_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/trdb_sample_fifo.md
# trdb_sample_fifo

Capture-and-buffer stage between the core's instruction-retire interface and the trace encoder. Qualifies each cycle's retire sample (valid instruction or exception/interrupt), packs it into a sample word and queues it in a small synchronous FIFO, so the encoder can back-pressure without stalling the core. On overflow it drops samples, flags the loss sticky, counts lost samples and marks the next accepted sample as a resync point.

## Interface
- DEPTH, 8, FIFO entries; power of two, >= 2
- CNT_W, 16, lost-sample counter width
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset; synchronous, active-low
- trace_enable_i  in  1  capture enable
- flush_i  in  1  discard all queued samples and clear status
- ivalid_i  in  1  instruction retired this cycle
- iexception_i  in  1  exception/interrupt taken this cycle
- interrupt_i  in  1  trap is an interrupt
- cause_i  in  5  trap cause
- tval_i  in  32  trap value
- priv_i  in  3  privilege level
- iaddr_i  in  32  instruction address
- instr_i  in  32  instruction word
- compressed_i  in  1  16-bit instruction
- sample_valid_o  out  1  head sample available
- sample_ready_i  in  1  encoder accepts head sample
- sample_o  out  trdb_sample_t  head sample (108 bits)
- overflow_o  out  1  sticky: at least one sample dropped
- lost_cnt_o  out  CNT_W  number of dropped samples, saturating

## Operation
- Capture condition: trace_enable_i && (ivalid_i || iexception_i). Non-qualifying cycles push nothing.
- Sample fields: exception, interrupt, cause, tval, priv, iaddr, instr, compressed, resync. All taken directly from inputs in the capture cycle.
- resync = 1 on the first sample accepted after reset, after flush, after trace_enable_i rises, and after any drop; 0 otherwise. Internal resync_pending flag is set by those events and cleared by the next accepted push.
- Pop: sample_valid_o && sample_ready_i. sample_valid_o = !empty; sample_o = storage[rd_ptr].
- Push when full: accepted only if a pop happens in the same cycle; otherwise the sample is dropped: overflow_o <= 1, lost_cnt_o += 1 (saturates at 2^CNT_W-1), resync_pending <= 1.
- Push and pop both on an empty FIFO: push stored, no bypass; pop not possible because valid is 0.
- flush_i has priority over everything: pointers and count reset to 0, overflow_o and lost_cnt_o cleared, resync_pending set. A sample presented in the flush cycle is discarded and not counted as lost.
- trace_enable_i low: no captures; queued entries keep draining normally.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy counter is log2(DEPTH)+1 bits.

## Timing
- Reset (rst_ni low at clock edge): sample_valid_o=0, overflow_o=0, lost_cnt_o=0, pointers/count=0, resync_pending=1. sample_o content is don't-care but must be driven (storage not reset).
- Latency: sample captured at edge N is visible on sample_o with sample_valid_o=1 after edge N, i.e. from cycle N+1.
- sample_o is stable while sample_valid_o && !sample_ready_i. Valid is never withdrawn without a pop, except on flush or reset.
- Throughput: one push and one pop per cycle sustained.
- overflow_o and lost_cnt_o update at the edge of the dropping cycle.

## Configuration
- TRDB_LOST_CNT_EN defined: lost_cnt_o is the saturating CNT_W counter described above.
- Undefined: no counter flops; lost_cnt_o tied to 0. overflow_o and resync behaviour are unchanged.

## Structure
- trdb_pkg holds: trdb_sample_t packed struct (field order as listed, resync as the LSB), XLEN=32, CAUSE_LEN=5, PRIV_LEN=3.
- One sub-module, trdb_sync_fifo: generic DEPTH×width storage with push/pop/full/empty and flush. Qualification, resync and loss accounting stay in the top.

## Test plan
- Reset, then 3 consecutive ivalid_i cycles with iaddr 0x100/0x104/0x108 and ready=1 -> three samples in order, each 1 cycle later; first has resync=1, the others resync=0.
- ready=0, DEPTH=8, 10 captures -> 8 stored, overflow_o=1, lost_cnt_o=2; after draining, the next capture has resync=1.
- Full FIFO with push and pop in the same cycle -> no drop, occupancy stays 8, lost_cnt_o unchanged.
- iexception_i=1, ivalid_i=0, cause=5'h0B, interrupt=0 -> one sample with exception=1, cause=0x0B.
- flush_i asserted together with a capture while 4 entries are queued -> next cycle sample_valid_o=0, overflow_o=0, lost_cnt_o=0; next capture has resync=1.
- TRDB_LOST_CNT_EN with CNT_W=2, 5 drops -> lost_cnt_o saturates at 3; macro undefined -> lost_cnt_o=0 throughout.
